// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream valid/ready handshake feeding the loader.
// master = upstream byte source, slave = loader.
interface inst_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/inst_loader.sv
// inst_loader: boot loader assembling big-endian words into imem, then releasing the core.
// Build option INST_LOADER_CKSUM_EN adds a trailing XOR checksum byte.
module inst_loader #(
   parameter int ADDR_W    = 12,
   parameter int MAX_WORDS = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   inst_loader_if.slave      s,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_run,
   output logic              err
);
   typedef enum logic [2:0] {
      S_HDR_HI,
      S_HDR_LO,
      S_PAYLOAD,
      S_FLUSH,
      S_CKSUM,
      S_RUN,
      S_ERROR
   } state_t;

   localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_cnt;
   logic [15:0]       r_words;
   logic [1:0]        r_bcnt;
   logic [31:0]       r_word;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic              r_ready;
   logic              w_acc;
   logic              w_last;
   logic              w_bad_hdr;
   logic              w_rdy_nxt;
   logic [15:0]       w_n;
`ifdef INST_LOADER_CKSUM_EN
   logic [7:0]        r_ck;
   logic              w_ck_ok;
`endif

   assign w_acc     = s.in_valid & r_ready;
   assign w_n       = {r_cnt[15:8], s.in_data};
   assign w_bad_hdr = (w_n == 16'd0) || ({1'b0, w_n} > LP_MAX);
   assign w_last    = (r_bcnt == 2'd3) && (r_words == r_cnt - 16'd1);
`ifdef INST_LOADER_CKSUM_EN
   assign w_ck_ok   = (r_ck ^ s.in_data) == 8'h00;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_HDR_HI;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_HDR_HI:  if (w_acc) w_state_nxt = S_HDR_LO;
         S_HDR_LO:  if (w_acc) w_state_nxt = w_bad_hdr ? S_ERROR : S_PAYLOAD;
`ifdef INST_LOADER_CKSUM_EN
         S_PAYLOAD: if (w_acc && w_last) w_state_nxt = S_CKSUM;
         S_CKSUM:   if (w_acc) w_state_nxt = w_ck_ok ? S_RUN : S_ERROR;
`else
         S_PAYLOAD: if (w_acc && w_last) w_state_nxt = S_FLUSH;
`endif
         S_FLUSH:   w_state_nxt = S_RUN;
         default:   w_state_nxt = r_state;
      endcase
   end

   // ready is registered, so it follows the state being entered
   assign w_rdy_nxt = w_state_nxt inside {S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_CKSUM};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready <= 1'b0;
         r_cnt   <= '0;
         r_words <= '0;
         r_bcnt  <= '0;
         r_word  <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
`ifdef INST_LOADER_CKSUM_EN
         r_ck    <= '0;
`endif
      end else begin
         r_ready <= w_rdy_nxt;
         r_we    <= 1'b0;
         if (r_we) r_addr <= r_addr + ADDR_W'(1);
         if (w_acc) begin
`ifdef INST_LOADER_CKSUM_EN
            r_ck <= r_ck ^ s.in_data;
`endif
            if (r_state == S_HDR_HI) r_cnt[15:8] <= s.in_data;
            if (r_state == S_HDR_LO) r_cnt[7:0]  <= s.in_data;
            if (r_state == S_PAYLOAD) begin
               r_word <= {r_word[23:0], s.in_data};
               r_bcnt <= r_bcnt + 2'd1;
               if (r_bcnt == 2'd3) begin
                  r_we    <= 1'b1;
                  r_words <= r_words + 16'd1;
               end
            end
         end
      end
   end

   assign s.in_ready = r_ready;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_word;
   assign core_run   = (r_state == S_RUN);
   assign err        = (r_state == S_ERROR);
endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader upstream of the single-cycle `mips_32` core. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them sequentially into the 4096-word instruction memory. Once the image is fully written it raises `core_run`, which gates the core's PC update. The core must not advance while `core_run` is low.

## Interface
Parameters:
- `ADDR_W`, default 12: instruction-memory word-address width.
- `MAX_WORDS`, default 4096: largest legal image size in words, and at most 2^ADDR_W.

Ports:
- `clk`: in, 1. Rising-edge clock.
- `rst_n`: in, 1. Reset, asynchronous and active-low.
- `in_valid`: in, 1. Upstream byte valid.
- `in_data`: in, 8. Upstream byte.
- `in_ready`: out, 1. Loader accepts a byte this cycle.
- `imem_we`: out, 1. One-cycle instruction-memory write strobe.
- `imem_addr`: out, ADDR_W. Word address of the write.
- `imem_wdata`: out, 32. Instruction word.
- `core_run`: out, 1. Image loaded; core may execute.
- `err`: out, 1. Malformed image; loader halted.

## Operation
- A byte is accepted only on an edge where `in_valid & in_ready`. When `in_ready` is low, `in_valid`/`in_data` are ignored. Upstream holds `in_data` until the byte is accepted.
- Stream format:
  - 2-byte header N, big-endian word count.
  - Then 4N payload bytes, each word MSB first.
  - Checksum byte, in the configured build only.
- States and transitions:
  - HDR_HI: accept the high byte of N, go to HDR_LO.
  - HDR_LO: accept the low byte of N. If N==0 or N>MAX_WORDS, go to ERROR. Otherwise go to PAYLOAD.
  - PAYLOAD: shift bytes into the word register. On each 4th byte, issue a write.
    - After the last byte of word N-1, go to FLUSH, or to CKSUM in the checksum build.
  - FLUSH: one cycle, `in_ready`=0, then RUN.
  - CKSUM: accept one byte. If it matches, go to RUN. Otherwise go to ERROR.
  - RUN and ERROR are terminal until reset. `in_ready`=0 in both.
- Write addressing: `imem_addr` starts at 0 and increments by 1 per written word. It never wraps, because N is bounded by MAX_WORDS.
- Word counter and byte counter are 16 bits and 2 bits respectively.
- `core_run` = 1 only in RUN. `err` = 1 only in ERROR.
- Reset mid-operation:
  - All state is cleared and the loader returns to HDR_HI with the address at 0.
  - Words already written stay in memory; they are overwritten by the next load.
  - `core_run` drops asynchronously with `rst_n`.

## Timing
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_run`=0, `err`=0. State is HDR_HI.
- `in_ready` is registered. It rises on the first `clk` edge after `rst_n` deasserts.
- Throughput: 1 byte per cycle in HDR_HI, HDR_LO, PAYLOAD and CKSUM when `in_valid` is held high.
- Write latency: `imem_we` is high for exactly the one cycle following the edge that accepted a word's 4th byte. `imem_addr`/`imem_wdata` are valid in that cycle.
- Last word accepted at edge e:
  - `imem_we`=1 in cycle e+1.
  - Without the checksum: FLUSH in cycle e+1, `core_run`=1 from cycle e+2.
  - With the checksum: CKSUM is entered at e. The checksum byte may be accepted at the earliest at edge e+1. RUN is entered at the following edge.
- The final write always completes before `core_run` rises.
- Illegal header: `err` rises in the cycle after the HDR_LO byte is accepted. No `imem_we` ever occurs.

## Configuration
- Macro: `INST_LOADER_CKSUM_EN`.
- Defined:
  - The CKSUM state exists.
  - The expected value is the XOR of all header and payload bytes, so the XOR over the whole stream including the checksum byte is 0x00.
  - Mismatch goes to ERROR with `core_run`=0. Words already written stay in memory.
- Undefined:
  - No checksum byte is expected; PAYLOAD goes to FLUSH.
  - No checksum logic is synthesised.

## Test plan
- **Single word, no checksum.** Stream 00 01 20 08 00 05 back-to-back.
  - One `imem_we` pulse with addr 0, data 0x20080005.
  - `core_run`=1 two cycles after the last byte is accepted.
  - `in_ready`=0 thereafter.
- **Zero-length image.** Header 00 00.
  - `err`=1 one cycle after the 2nd byte, `in_ready`=0.
  - No writes; `core_run` stays 0.
- **Oversize header.** Header 10 01 (4097).
  - `err`=1, no writes.
- **Backpressure.** 3 words, with `in_valid` toggled randomly and bytes held while `in_ready`=0.
  - Writes to addr 0, 1, 2 with the correct words.
  - Byte order is preserved across gaps.
- **Reset mid-payload.** Assert `rst_n`=0 after 6 bytes of a 2-word image.
  - All outputs go to 0 immediately.
  - A reload of a 1-word image writes addr 0 and reaches RUN.
- **Checksum build (`INST_LOADER_CKSUM_EN`).**
  - Stream 00 01 20 08 00 05 2C reaches RUN.
  - The same stream ending 2D gives `err`=1 and `core_run`=0. The single word has still been written at addr 0.
